// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with PC register and prefetch FIFO
// Fetches one word per cycle from a combinational ROM into a FIFO feeding decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          pop;
  logic          push;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

  // Redirect squashes both sides, so a coincident handshake is not a transfer.
  assign if_valid  = (count != '0);
  assign pop       = if_valid & if_ready & ~redirect_valid;
  assign push      = ~redirect_valid & ((count < DEPTH_C) | pop);
  assign imem_addr = fetch_pc;
  assign if_instr  = if_valid ? instr_mem[rd_ptr] : 32'h0;
  assign if_pc     = if_valid ? pc_mem[rd_ptr]    : 32'h0;

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= imem_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW + 1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
// Expected {pc,instr} streams are queued when reset/redirect is driven and popped on each transfer.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int tests_run = 0;
  int tests_failed = 0;
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_instr = rom(imem_addr);

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_instr(if_instr),
    .if_pc(if_pc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic sb_reset(input logic [31:0] start);
    logic [31:0] pc;
    sb.delete();
    pc = {start[31:2], 2'b00};
    for (int i = 0; i < 40; i++) begin
      sb.push_back({pc, rom(pc)});
      pc = pc + 32'd4;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Inputs change only at posedge+1, so the values seen here are those the next edge uses.
  always @(negedge clk) begin
    logic [63:0] exp;
    if (!rst && if_valid && if_ready && !redirect_valid) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp = sb.pop_front();
        check("xfer_pc", if_pc, exp[63:32]);
        check("xfer_instr", if_instr, exp[31:0]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    if_ready = 1'b0;
    step(2);
    check("rst_if_valid", {31'h0, if_valid}, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);

    // Reset release and streaming
    rst = 1'b0;
    if_ready = 1'b1;
    sb_reset(32'h0);
    step(1);
    check("c1_if_valid", {31'h0, if_valid}, 32'h1);
    check("c1_if_pc", if_pc, 32'h0);
    step(8);

    // Back-pressure, then full with simultaneous push/pop
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    if_ready = 1'b0;
    sb_reset(32'h0);
    step(10);
    check("bp_imem_addr", imem_addr, 32'h10);
    check("bp_if_valid", {31'h0, if_valid}, 32'h1);
    check("bp_if_pc", if_pc, 32'h0);
    step(1);
    check("bp_hold_pc", if_pc, 32'h0);
    check("bp_hold_instr", if_instr, 32'h1000_0000);
    if_ready = 1'b1;
    step(1);
    check("full_pp_addr", imem_addr, 32'h14);
    check("full_pp_pc", if_pc, 32'h4);
    if_ready = 1'b0;
    step(1);
    check("full_stall_addr", imem_addr, 32'h14);
    if_ready = 1'b1;
    step(6);

    // Redirect flush with 3 entries buffered
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    if_ready = 1'b0;
    sb_reset(32'h0);
    step(3);
    check("rd3_imem_addr", imem_addr, 32'hC);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    sb_reset(32'h0000_0100);
    step(1);
    redirect_valid = 1'b0;
    check("rd_n1_valid", {31'h0, if_valid}, 32'h0);
    check("rd_n1_addr", imem_addr, 32'h100);
    step(1);
    check("rd_n2_valid", {31'h0, if_valid}, 32'h1);
    check("rd_n2_pc", if_pc, 32'h100);
    check("rd_n2_instr", if_instr, rom(32'h100));
    if_ready = 1'b1;
    step(4);

    // Redirect coinciding with a handshake
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    sb_reset(32'h0000_0200);
    step(1);
    redirect_valid = 1'b0;
    check("rdh_n1_valid", {31'h0, if_valid}, 32'h0);
    check("rdh_n1_addr", imem_addr, 32'h200);
    step(1);
    check("rdh_n2_pc", if_pc, 32'h200);
    step(4);

    // Back-to-back redirects, last one wins
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    sb_reset(32'h0000_0300);
    step(1);
    redirect_pc = 32'h0000_0402;
    sb_reset(32'h0000_0400);
    step(1);
    redirect_valid = 1'b0;
    check("b2b_n1_valid", {31'h0, if_valid}, 32'h0);
    check("b2b_n1_addr", imem_addr, 32'h400);
    step(1);
    check("b2b_n2_pc", if_pc, 32'h400);
    step(3);

    // Reset mid-stream with 2 entries buffered, overriding a redirect
    if_ready = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    sb_reset(32'h0);
    step(2);
    check("mid_imem_addr", imem_addr, 32'h8);
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    step(1);
    rst = 1'b0;
    redirect_valid = 1'b0;
    sb_reset(32'h0);
    check("mid_rst_valid", {31'h0, if_valid}, 32'h0);
    check("mid_rst_addr", imem_addr, 32'h0);
    if_ready = 1'b1;
    step(3);

    // PC wrap
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    sb_reset(32'hFFFF_FFFC);
    step(1);
    redirect_valid = 1'b0;
    check("wrap_n1_addr", imem_addr, 32'hFFFF_FFFC);
    step(1);
    check("wrap_n2_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_n2_addr", imem_addr, 32'h0);
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that owns the program counter. Each cycle it drives the word address into the combinational instruction ROM and captures the returned instruction with its PC into a small prefetch FIFO. It presents those instructions to decode through a valid/ready handshake. It absorbs decode back-pressure and flushes on control-flow redirects from execute.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `DEPTH`, default 4: prefetch FIFO entries. Must be a power of 2 and at least 2.
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_addr`  out  32: fetch address to the instruction ROM. Driven directly from the fetch PC register.
- `imem_instr`  in  32: instruction returned combinationally for `imem_addr` in the same cycle.
- `redirect_valid`  in  1: redirect request from execute (taken branch or jump).
- `redirect_pc`  in  32: redirect target. Bits [1:0] are ignored and treated as 00.
- `if_valid`  out  1: the FIFO head holds a valid instruction.
- `if_ready`  in  1: decode accepts the head this cycle.
- `if_instr`  out  32: instruction at the FIFO head. Reads 0 when the FIFO is empty.
- `if_pc`  out  32: PC of the head instruction. Reads 0 when the FIFO is empty.

## Operation
- State:
  - fetch PC, 32 bits.
  - FIFO of DEPTH entries, each {pc[31:0], instr[31:0]}.
  - rd_ptr and wr_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - count, log2(DEPTH)+1 bits.
- `imem_addr` = fetch PC at all times. Fetch PC bits [1:0] are always 00.
- pop = `if_valid` & `if_ready` & !`redirect_valid`.
- push = !`redirect_valid` & (count < DEPTH | pop).
  - Push while full is legal only when a pop happens in the same cycle.
- On push:
  - Write {fetch PC, `imem_instr`} at wr_ptr.
  - wr_ptr += 1.
  - Fetch PC += 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- On pop: rd_ptr += 1.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- No push: fetch PC holds and the same address is re-presented next cycle. The ROM read is simply repeated.
- Redirect (`redirect_valid`=1), highest priority after `rst`:
  - FIFO cleared: count=0, rd_ptr=wr_ptr=0.
  - Fetch PC <= {redirect_pc[31:2], 2'b00}.
  - No push and no pop take effect. The ROM word read this cycle is discarded.
- A handshake that coincides with `redirect_valid` does not count as a transfer. Decode is flushed by the same redirect and must drop that instruction.
- `if_valid` = (count != 0). It does not depend combinationally on `redirect_valid` or `if_ready`.
- `if_instr` and `if_pc` are the head entry when count != 0, else 0.
- Reset (`rst`=1 at an edge), overriding everything including redirect:
  - Fetch PC <= RESET_PC with bits [1:0] cleared.
  - count=0, rd_ptr=wr_ptr=0.
  - FIFO storage contents are don't-care.
  - Applies identically mid-stream: all buffered instructions are lost.
- Reset values of outputs:
  - `imem_addr`=RESET_PC.
  - `if_valid`=0, `if_instr`=0, `if_pc`=0.

## Timing
- Fetch-to-decode latency is one cycle:
  - Address presented in cycle N is pushed at the end of N.
  - It appears at the FIFO head with `if_valid`=1 in N+1, provided the FIFO was empty.
- After `rst` deasserts (first non-reset cycle C0):
  - `imem_addr`=RESET_PC in C0.
  - `if_valid`=1 with `if_pc`=RESET_PC in C1.
- With `if_ready` held at 1, throughput is one instruction per cycle with sequential PCs.
- With `if_ready` held at 0:
  - The FIFO fills in DEPTH cycles, after which fetch PC stalls.
  - Outputs hold stable while `if_valid`=1 and `if_ready`=0 (standard valid/ready rule).
- Redirect latency, with redirect asserted in cycle N:
  - `if_valid`=0 in N+1, with `imem_addr`=target.
  - `if_valid`=1 with `if_pc`=target in N+2.
- Back-to-back redirects: the last one wins. Each resets the two-cycle latency.

## Test plan
- Reset and stream:
  - Stimulus: RESET_PC=0, ROM word k = 32'h1000_0000+k, `if_ready`=1.
  - Required: `if_valid` rises one cycle after reset release. Consecutive transfers carry pc 0,4,8,... with instr 10000000,10000001,...; no gaps or duplicates.
- Back-pressure:
  - Stimulus: `if_ready`=0 for 10 cycles, then `if_ready`=1.
  - Required: exactly 4 entries buffered (pc 0..C). `imem_addr` stalls at 0x10. After release, pcs 0,4,8,C,10 drain in order with no loss.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full, `if_ready`=1 for one cycle.
  - Required: one pop and one push. count stays 4. `imem_addr` advances by 4.
- Redirect flush:
  - Stimulus: FIFO holding 3 entries, `redirect_valid`=1, `redirect_pc`=32'h0000_0103.
  - Required: next cycle `if_valid`=0 and `imem_addr`=0x100. The cycle after, `if_pc`=0x100. No stale pre-redirect instruction ever accepted.
- Redirect coinciding with `if_ready`=1:
  - Required: head is not popped (pointers cleared, not advanced). Subsequent stream starts at the target.
- Reset mid-stream and PC wrap:
  - Reset mid-stream: `rst` while 2 entries are buffered gives `if_valid`=0 and `imem_addr`=RESET_PC next cycle.
  - PC wrap: redirect to 32'hFFFF_FFFC yields pcs FFFFFFFC, then 00000000.
